// File: rtl/cpu_imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// cpu_imem_load_ctrl
//   Arbitrates the single port of the 64 KiB CPU instruction memory between
//   the host/DMA program loader and CPU instruction fetch. A load writes a
//   word stream to consecutive word addresses starting at load_base while the
//   CPU is held; once the last word is written the port is handed to fetch
//   (AUTO_RUN=1) or the block parks in IDLE until run_start (AUTO_RUN=0).
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   load_start/base/len   load request (pulse), byte base (4-aligned), words
//   run_start             IDLE -> RUN pulse
//   host_valid/data/ready word stream from the host, ready only in LOAD
//   cpu_fetch_req/addr    fetch request from the CPU (honoured only in RUN)
//   cpu_instr/_valid      fetched word, valid one cycle after the request
//   cpu_run               CPU may execute
//   load_done/load_err    1-cycle completion / rejection pulses
//   mem_addr/wrt_en/wrt_data, mem_rd_out   memory port (1-cycle read)
// ---------------------------------------------------------------------------
module cpu_imem_load_ctrl #(
    parameter bit AUTO_RUN = 1'b1,
    parameter int LEN_W    = 15
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_start,
    input  logic [15:0]      load_base,
    input  logic [LEN_W-1:0] load_len,
    input  logic             run_start,
    input  logic             host_valid,
    input  logic [31:0]      host_data,
    output logic             host_ready,
    input  logic             cpu_fetch_req,
    input  logic [15:0]      cpu_fetch_addr,
    output logic [31:0]      cpu_instr,
    output logic             cpu_instr_valid,
    output logic             cpu_run,
    output logic             load_done,
    output logic             load_err,
    output logic [15:0]      mem_addr,
    output logic             mem_wrt_en,
    output logic [31:0]      mem_wrt_data,
    input  logic [31:0]      mem_rd_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_RUN  = 2'd2
    } state_t;

    // End-address width: wide enough that base + 4*len can never wrap.
    localparam int EW = ((LEN_W + 2 > 16) ? LEN_W + 2 : 16) + 1;

    state_t           state, state_nxt;
    logic [15:0]      wr_ptr, wr_ptr_nxt;
    logic [LEN_W-1:0] remaining, remaining_nxt;
    logic             done_q, done_nxt;
    logic             err_q, err_nxt;
    logic             fetch_q;
    logic             run_q;

    logic             wr_fire;
    logic             load_ok;
    logic [EW-1:0]    end_addr;
    state_t           post_load;

    // Where a completed (or empty) load leaves the controller.
    assign post_load = AUTO_RUN ? S_RUN : S_IDLE;

    assign end_addr = {{(EW-16){1'b0}}, load_base}
                    + {{(EW-LEN_W-2){1'b0}}, load_len, 2'b00};
    assign load_ok  = (load_base[1:0] == 2'b00) && (end_addr <= EW'(32'h0001_0000));

    assign wr_fire  = (state == S_LOAD) && host_valid;

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            wr_ptr    <= '0;
            remaining <= '0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            fetch_q   <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state     <= state_nxt;
            wr_ptr    <= wr_ptr_nxt;
            remaining <= remaining_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            // A fetch taken in the last RUN cycle still returns its word
            // even if the controller is leaving RUN.
            fetch_q   <= (state == S_RUN) && cpu_fetch_req;
            run_q     <= (state_nxt == S_RUN);
        end
    end

    // ------------------------------------------------------ next state
    always_comb begin
        state_nxt     = state;
        wr_ptr_nxt    = wr_ptr;
        remaining_nxt = remaining;
        done_nxt      = 1'b0;
        err_nxt       = 1'b0;

        unique case (state)
            S_LOAD: begin
                // load_start is deliberately ignored while a load is running.
                if (wr_fire) begin
                    wr_ptr_nxt    = wr_ptr + 16'd4;
                    remaining_nxt = remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) begin
                        state_nxt = post_load;
                        done_nxt  = 1'b1;
                    end
                end
            end

            S_IDLE, S_RUN: begin
                // load_start has priority over run_start.
                if (load_start) begin
                    if (!load_ok) begin
                        err_nxt = 1'b1;
                    end else if (load_len == '0) begin
                        state_nxt = post_load;
                        done_nxt  = 1'b1;
                    end else begin
                        state_nxt     = S_LOAD;
                        wr_ptr_nxt    = load_base;
                        remaining_nxt = load_len;
                    end
                end else if (run_start && (state == S_IDLE)) begin
                    state_nxt = S_RUN;
                end
            end

            default: state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------ memory port
    always_comb begin
        mem_addr = '0;
        unique case (state)
            S_LOAD:  mem_addr = wr_ptr;
            S_RUN:   mem_addr = cpu_fetch_addr;
            default: mem_addr = '0;
        endcase
    end

    assign mem_wrt_en      = wr_fire;
    assign mem_wrt_data    = wr_fire ? host_data : 32'h0;

    assign host_ready      = (state == S_LOAD);
    assign cpu_instr       = mem_rd_out;
    assign cpu_instr_valid = fetch_q;
    assign cpu_run         = run_q;
    assign load_done       = done_q;
    assign load_err        = err_q;

endmodule

// File: tb/tb_cpu_imem_load_ctrl.sv
// ---------------------------------------------------------------------------
// tb_cpu_imem_load_ctrl
//   Two controllers (AUTO_RUN=1 and AUTO_RUN=0) share one stimulus stream,
//   each with its own instruction memory. A per-controller reference model
//   tracks the load/run phase, write pointer, remaining count and a memory
//   image, and every cycle's outputs are compared against it. Directed
//   sequences and a vector table add explicit expectations on top.
// ---------------------------------------------------------------------------
module tb_cpu_imem_load_ctrl;

    localparam int LEN_W = 15;
    localparam int P_IDLE = 0, P_LOAD = 1, P_RUN = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // shared stimulus
    logic             ls = 0, rs = 0, hv = 0, fr = 0;
    logic [15:0]      lb = 0, fa = 0;
    logic [LEN_W-1:0] ll = 0;
    logic [31:0]      hd = 0;

    // per-DUT outputs, index 0: AUTO_RUN=1, index 1: AUTO_RUN=0
    logic        hr [2], civ [2], crun [2], ldone [2], lerr [2], wen [2];
    logic [31:0] cinstr [2], wdata [2], rd [2];
    logic [15:0] maddr [2];

    cpu_imem_load_ctrl #(.AUTO_RUN(1'b1), .LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n), .load_start(ls), .load_base(lb), .load_len(ll),
        .run_start(rs), .host_valid(hv), .host_data(hd), .host_ready(hr[0]),
        .cpu_fetch_req(fr), .cpu_fetch_addr(fa), .cpu_instr(cinstr[0]),
        .cpu_instr_valid(civ[0]), .cpu_run(crun[0]), .load_done(ldone[0]),
        .load_err(lerr[0]), .mem_addr(maddr[0]), .mem_wrt_en(wen[0]),
        .mem_wrt_data(wdata[0]), .mem_rd_out(rd[0]));

    cpu_imem_load_ctrl #(.AUTO_RUN(1'b0), .LEN_W(LEN_W)) dut_m (
        .clk(clk), .rst_n(rst_n), .load_start(ls), .load_base(lb), .load_len(ll),
        .run_start(rs), .host_valid(hv), .host_data(hd), .host_ready(hr[1]),
        .cpu_fetch_req(fr), .cpu_fetch_addr(fa), .cpu_instr(cinstr[1]),
        .cpu_instr_valid(civ[1]), .cpu_run(crun[1]), .load_done(ldone[1]),
        .load_err(lerr[1]), .mem_addr(maddr[1]), .mem_wrt_en(wen[1]),
        .mem_wrt_data(wdata[1]), .mem_rd_out(rd[1]));

    // memories: 1-cycle registered read, write-then-read of old data
    logic [31:0] mem0 [16384];
    logic [31:0] mem1 [16384];
    logic [47:0] wlog [$];   // {addr, data} of every write by the AUTO_RUN=1 DUT

    always @(posedge clk) begin
        if (wen[0]) begin
            mem0[maddr[0][15:2]] <= wdata[0];
            wlog.push_back({maddr[0], wdata[0]});
        end
        rd[0] <= mem0[maddr[0][15:2]];
        if (wen[1]) mem1[maddr[1][15:2]] <= wdata[1];
        rd[1] <= mem1[maddr[1][15:2]];
    end

    // ---------------------------------------------------- reference model
    int          ph [2], ptr [2], rem [2];
    bit          dp [2], ep [2], fvp [2];
    logic [31:0] fip [2];
    logic [31:0] img [2][16384];

    int nchk = 0, nerr = 0;

    task automatic chk(input string nm, input int k, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s[%0d]: got %h expected %h", nm, k, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            ph[k] = P_IDLE; ptr[k] = 0; rem[k] = 0;
            dp[k] = 0; ep[k] = 0; fvp[k] = 0; fip[k] = 0;
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < 2; k++) begin
            bit we;
            we = (ph[k] == P_LOAD) && hv;
            chk("host_ready", k, 32'(hr[k]), 32'(ph[k] == P_LOAD));
            chk("mem_wrt_en", k, 32'(wen[k]), 32'(we));
            if (we) begin
                chk("wr_addr", k, 32'(maddr[k]), 32'(ptr[k]));
                chk("wr_data", k, wdata[k], hd);
            end else if (ph[k] == P_RUN) begin
                chk("fetch_addr", k, 32'(maddr[k]), 32'(fa));
            end else if (ph[k] == P_IDLE) begin
                chk("idle_addr", k, 32'(maddr[k]), 32'h0);
            end
            chk("cpu_run", k, 32'(crun[k]), 32'(ph[k] == P_RUN));
            chk("load_done", k, 32'(ldone[k]), 32'(dp[k]));
            chk("load_err", k, 32'(lerr[k]), 32'(ep[k]));
            chk("instr_valid", k, 32'(civ[k]), 32'(fvp[k]));
            if (fvp[k]) chk("instr", k, cinstr[k], fip[k]);
        end
    endtask

    task automatic model_step();
        for (int k = 0; k < 2; k++) begin
            int nph;
            bit nd, ne;
            nph = ph[k]; nd = 0; ne = 0;
            fvp[k] = (ph[k] == P_RUN) && fr;
            fip[k] = img[k][fa[15:2]];
            if (ph[k] == P_LOAD) begin
                if (hv) begin
                    img[k][ptr[k] / 4] = hd;
                    ptr[k] = (ptr[k] + 4) % 65536;
                    rem[k] = rem[k] - 1;
                    if (rem[k] == 0) begin
                        nph = (k == 0) ? P_RUN : P_IDLE;
                        nd = 1;
                    end
                end
            end else if (ls) begin
                if ((int'(lb) % 4 == 0) && (int'(lb) + 4 * int'(ll) <= 65536)) begin
                    if (ll == 0) begin
                        nd = 1;
                        nph = (k == 0) ? P_RUN : P_IDLE;
                    end else begin
                        ptr[k] = int'(lb); rem[k] = int'(ll); nph = P_LOAD;
                    end
                end else begin
                    ne = 1;
                end
            end else if (rs && ph[k] == P_IDLE) begin
                nph = P_RUN;
            end
            ph[k] = nph; dp[k] = nd; ep[k] = ne;
        end
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic cyc();
        #1;
        check_all();
        model_step();
        @(negedge clk);
    endtask

    task automatic quiet();
        ls = 0; rs = 0; hv = 0; fr = 0;
    endtask

    task automatic start_load(input logic [15:0] base, input int len);
        quiet();
        ls = 1; lb = base; ll = LEN_W'(len);
        cyc();
        ls = 0;
    endtask

    // Feeds random words (optionally every other cycle) until the load ends.
    task automatic feed(input bit gaps, input int budget);
        int i;
        i = 0;
        while (ph[0] == P_LOAD && i < budget) begin
            hv = gaps ? i[0] : 1'b1;
            hd = $urandom;
            cyc();
            i++;
        end
        hv = 0;
        if (ph[0] == P_LOAD) chk("feed_timeout", 0, 32'd1, 32'd0);
    endtask

    typedef struct {
        logic [15:0] base;
        int          len;
        bit          exp_err;
        bit          exp_done_now;
    } vec_t;

    vec_t tbl [7];

    initial begin
        for (int i = 0; i < 16384; i++) begin
            mem0[i] = 0; mem1[i] = 0; img[0][i] = 0; img[1][i] = 0;
        end
        tbl[0] = '{16'h0002, 4,    1'b1, 1'b0};
        tbl[1] = '{16'hFFF8, 3,    1'b1, 1'b0};
        tbl[2] = '{16'hFFF8, 2,    1'b0, 1'b0};
        tbl[3] = '{16'h0000, 0,    1'b0, 1'b1};
        tbl[4] = '{16'hFFFC, 1,    1'b0, 1'b0};
        tbl[5] = '{16'h0001, 0,    1'b1, 1'b0};
        tbl[6] = '{16'h8000, 8193, 1'b1, 1'b0};

        // ---- reset state
        model_reset();
        #2;
        check_all();
        chk("rst_wdata", 0, wdata[0], 32'h0);
        chk("rst_maddr", 0, 32'(maddr[0]), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        // ---- 4-word load at 0x0000, continuous
        wlog.delete();
        start_load(16'h0000, 4);
        for (int i = 0; i < 4; i++) begin
            hv = 1; hd = 32'h11111111 * (i + 1);
            cyc();
        end
        hv = 0;
        chk("a_done", 0, 32'(ldone[0]), 32'd1);
        chk("a_run", 0, 32'(crun[0]), 32'd1);
        chk("a_done_m", 1, 32'(ldone[1]), 32'd1);
        chk("a_run_m", 1, 32'(crun[1]), 32'd0);
        chk("a_nwr", 0, wlog.size(), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            chk("a_wr_addr", i, 32'(wlog[i][47:32]), 32'(4 * i));
            chk("a_wr_data", i, wlog[i][31:0], 32'h11111111 * (i + 1));
        end
        fr = 1; fa = 16'h0008;
        cyc();
        fr = 0;
        chk("a_fetch_v", 0, 32'(civ[0]), 32'd1);
        chk("a_fetch_d", 0, cinstr[0], 32'h33333333);
        cyc();

        // ---- back-pressure: host_valid every other cycle
        wlog.delete();
        start_load(16'h0000, 4);
        chk("b_run_drop", 0, 32'(crun[0]), 32'd0);
        for (int i = 0; i < 8; i++) begin
            hv = i[0]; hd = 32'hB0000000 + 32'(i / 2);
            cyc();
        end
        hv = 0;
        chk("b_done", 0, 32'(ldone[0]), 32'd1);
        chk("b_nwr", 0, wlog.size(), 32'd4);
        for (int i = 0; i < 4 && i < wlog.size(); i++)
            chk("b_wr_addr", i, 32'(wlog[i][47:32]), 32'(4 * i));

        // ---- acceptance-check table
        for (int t = 0; t < 7; t++) begin
            wlog.delete();
            start_load(tbl[t].base, tbl[t].len);
            chk("tbl_err", t, 32'(lerr[0]), 32'(tbl[t].exp_err));
            chk("tbl_done", t, 32'(ldone[0]), 32'(tbl[t].exp_done_now));
            chk("tbl_ready", t, 32'(hr[0]),
                32'(!tbl[t].exp_err && !tbl[t].exp_done_now));
            feed(1'b0, 64);
            if (t == 2) chk("tbl_last_addr", t,
                            wlog.size() > 0 ? 32'(wlog[wlog.size()-1][47:32]) : 32'hDEAD,
                            32'h0000FFFC);
            cyc();
        end

        // ---- reload from RUN with a fetch in the load_start cycle
        wlog.delete();
        quiet();
        ls = 1; lb = 16'h0100; ll = 1; fr = 1; fa = 16'h0008;
        cyc();
        quiet();
        chk("r_run_drop", 0, 32'(crun[0]), 32'd0);
        chk("r_fetch_v", 0, 32'(civ[0]), 32'd1);
        chk("r_fetch_d", 0, cinstr[0], 32'hB0000002);
        hv = 1; hd = 32'hCAFEF00D;
        cyc();
        hv = 0;
        chk("r_nwr", 0, wlog.size(), 32'd1);
        if (wlog.size() > 0) chk("r_wr_addr", 0, 32'(wlog[0][47:32]), 32'h0100);
        chk("r_run_back", 0, 32'(crun[0]), 32'd1);

        // ---- AUTO_RUN=0 behaviour (DUT 1 is parked in IDLE here)
        chk("m_idle", 1, 32'(crun[1]), 32'd0);
        rs = 1;
        cyc();
        rs = 0;
        chk("m_run", 1, 32'(crun[1]), 32'd1);
        start_load(16'h0000, 0);   // empty load: DUT 1 back to IDLE
        chk("m_empty_idle", 1, 32'(crun[1]), 32'd0);
        ls = 1; rs = 1; lb = 16'h0500; ll = 1;
        cyc();
        quiet();
        chk("m_both_load", 1, 32'(hr[1]), 32'd1);
        chk("m_both_run", 1, 32'(crun[1]), 32'd0);
        feed(1'b0, 8);
        rs = 1;
        cyc();
        rs = 0;
        chk("m_run2", 1, 32'(crun[1]), 32'd1);

        // ---- reset after 2 of 4 words
        start_load(16'h0200, 4);
        hv = 1; hd = 32'h0A0A0A0A; cyc();
        hd = 32'h0B0B0B0B; cyc();
        quiet();
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        chk("x_ready", 0, 32'(hr[0]), 32'd0);
        chk("x_wdata", 0, wdata[0], 32'h0);
        @(negedge clk);
        rst_n = 1;
        wlog.delete();
        start_load(16'h0300, 2);
        feed(1'b0, 8);
        chk("x_nwr", 0, wlog.size(), 32'd2);
        if (wlog.size() == 2) begin
            chk("x_addr0", 0, 32'(wlog[0][47:32]), 32'h0300);
            chk("x_addr1", 0, 32'(wlog[1][47:32]), 32'h0304);
        end
        cyc();

        // ---- randomized traffic against the model
        for (int n = 0; n < 2500; n++) begin
            quiet();
            if ($urandom_range(0, 19) == 0) begin
                ls = 1;
                lb = ($urandom_range(0, 9) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255) * 4);
                ll = ($urandom_range(0, 9) == 0) ? LEN_W'($urandom_range(16000, 16384))
                                                 : LEN_W'($urandom_range(0, 6));
            end
            rs = ($urandom_range(0, 24) == 0);
            hv = ($urandom_range(0, 9) < 7);
            hd = $urandom;
            fr = ($urandom_range(0, 9) < 6);
            fa = 16'($urandom_range(0, 1023));
            // long loads would dominate the run; finish them quickly
            if (ph[0] == P_LOAD && rem[0] > 16) ll = 0;
            cyc();
            if (ph[0] == P_LOAD && rem[0] > 16) begin
                quiet();
                feed(1'b0, 17000);
            end
        end
        quiet();
        cyc();

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/cpu_imem_load_ctrl.md
Name: cpu_imem_load_ctrl

Overview:
- Owns the single port of the CPU instruction memory: 64 KiB, byte-addressed, 32-bit little-endian word write/read, 1-cycle registered read.
- Sequences program loading: a host/DMA word stream is written to consecutive word addresses.
- Holds the CPU halted during a load and hands the port to CPU instruction fetch once loading completes.
- Sits between the DMA/host interface, the CPU fetch stage and the memory.

Parameters:
- AUTO_RUN, 1, 1: enter RUN after a successful load; 0: return to IDLE and wait for run_start.
- LEN_W, 15, width of load_len in words; max legal 16384 words (full 64 KiB).

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- load_start  input  1  1-cycle pulse; begin a load using load_base/load_len sampled this cycle
- load_base  input  16  byte start address; must be 4-aligned
- load_len  input  LEN_W  number of 32-bit words to load
- run_start  input  1  1-cycle pulse; IDLE->RUN (used when AUTO_RUN=0)
- host_valid  input  1  host word valid
- host_data  input  32  host word
- host_ready  output  1  controller accepts host word
- cpu_fetch_req  input  1  CPU fetch request
- cpu_fetch_addr  input  16  CPU fetch byte address
- cpu_instr  output  32  fetched instruction (mem_rd_out passthrough)
- cpu_instr_valid  output  1  cpu_instr valid this cycle
- cpu_run  output  1  CPU may execute; low = CPU held/stalled
- load_done  output  1  1-cycle pulse on successful load completion
- load_err  output  1  1-cycle pulse on rejected load_start
- mem_addr  output  16  memory byte address
- mem_wrt_en  output  1  memory write enable
- mem_wrt_data  output  32  memory write data
- mem_rd_out  input  32  memory registered read data

Behaviour:
- Reset (async, rst_n low): state=IDLE; write pointer=0; words-remaining=0.
  - Reset values: cpu_run=0, host_ready=0, cpu_instr_valid=0, load_done=0, load_err=0, mem_wrt_en=0, mem_addr=0, mem_wrt_data=0.
- States:
  - IDLE: CPU halted.
  - LOAD: host owns the memory port.
  - RUN: CPU owns the memory port.
- Load acceptance:
  - load_start is legal in any state.
  - Check: load_base[1:0]==0 and load_base + 4*load_len <= 0x10000, computed at 17+ bits (no wrap).
  - Check fails: load_err pulses the next cycle; state and pointers are unchanged.
  - Check passes with load_len==0: load_done pulses the next cycle; go to RUN (AUTO_RUN=1) or IDLE.
  - Check passes otherwise: wr_ptr=load_base, remaining=load_len; go to LOAD next cycle; cpu_run deasserts the cycle after load_start.
- LOAD:
  - host_ready=1, combinational from state.
  - Each cycle with host_valid&&host_ready: mem_wrt_en=1, mem_addr=wr_ptr, mem_wrt_data=host_data (all combinational); wr_ptr+=4, remaining-=1.
  - Gaps in host_valid are allowed: no write, no pointer change.
  - Accepting the final word (remaining==1): next cycle state=RUN (AUTO_RUN=1) or IDLE, load_done=1 for one cycle, host_ready=0.
  - load_start while in LOAD is ignored (no error, no restart).
- RUN:
  - cpu_run=1 (registered).
  - mem_addr=cpu_fetch_addr and mem_wrt_en=0, both combinational.
  - cpu_fetch_req high in cycle N -> cpu_instr_valid=1 in cycle N+1 with cpu_instr=mem_rd_out.
  - Back-to-back fetches: one instruction per cycle.
- IDLE:
  - mem_addr=0, no writes, cpu_instr_valid=0.
  - run_start moves to RUN next cycle; run_start is ignored in LOAD and RUN.
- Fetch handling:
  - Fetch requests are ignored outside RUN.
  - A fetch accepted in the last RUN cycle before a reload still produces cpu_instr_valid in the following cycle.
- Simultaneous events: load_start and run_start in the same cycle -> load_start wins.
- Reset mid-LOAD: immediate return to IDLE; partially written memory contents are left as-is; host_ready drops asynchronously.

Test Plan:
- Load 4 words at base 0x0000 (0x11111111, 0x22222222, 0x33333333, 0x44444444), host_valid continuous.
  - Writes go to 0x0000/0x0004/0x0008/0x000C on consecutive cycles.
  - load_done pulses once; cpu_run=1 the same cycle.
  - Fetch of 0x0008 returns 0x33333333 with cpu_instr_valid one cycle later.
- Back-pressure: same load with host_valid low every other cycle -> exactly 4 writes, addresses increment only on accepted words, load_done after the 4th.
- Errors:
  - load_base=0x0002 -> load_err pulse, state unchanged.
  - load_base=0xFFF8, load_len=3 -> load_err.
  - load_base=0xFFF8, load_len=2 -> accepted; last write at 0xFFFC.
- Reload from RUN with load_base=0x0100, load_len=1 -> cpu_run=0 the next cycle; a fetch issued in the load_start cycle still returns valid data; single write at 0x0100; RUN resumes.
- AUTO_RUN=0: load completes -> IDLE with cpu_run=0; run_start -> cpu_run=1. load_start and run_start in the same cycle -> load taken.
- rst_n low after 2 of 4 words -> all outputs at reset values immediately; a new load afterwards starts cleanly from its own load_base.
